// File: rtl/pixel_stream_pkg.sv
//------------------------------------------------------------------------------
// Module   : pixel_stream_pkg
// Brief    : Shared FSM state type and default image geometry for the pixel
//            source and the convolution block it feeds.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pixel_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int c_default_bitwidth     = 8;
    localparam int c_default_image_width  = 11;
    localparam int c_default_image_height = 4;

    // A one-pixel frame still needs a 1-bit address bus.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_frame_ram.sv
//------------------------------------------------------------------------------
// Module   : pixel_frame_ram
// Brief    : Single-clock frame buffer, one write port and one registered
//            read-first read port. Out-of-range writes are dropped.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pixel_frame_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 44,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rd_data;
    logic             w_wr_ok;

    assign w_wr_ok   = i_wr_en && ({1'b0, i_wr_addr} < c_depth);
    assign o_rd_data = r_rd_data;

    // Non-blocking update order makes a same-address read return the old word.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_stream_source.sv
//------------------------------------------------------------------------------
// Module   : pixel_stream_source
// Brief    : Streams one stored frame in raster order on request, with
//            downstream pause. Optional self-inserted gaps under macro
//            PIXEL_SOURCE_GAP_EN (adds input gap_period).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pixel_stream_source
    import pixel_stream_pkg::*;
#(
    parameter int bitwidth    = c_default_bitwidth,
    parameter int imageWidth  = c_default_image_width,
    parameter int imageHeight = c_default_image_height,
    localparam int N          = imageWidth * imageHeight,
    localparam int AW         = addr_width(N)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [bitwidth-1:0] wr_data,
`ifdef PIXEL_SOURCE_GAP_EN
    input  logic [7:0]          gap_period,
`endif
    input  logic                start,
    input  logic                pause,
    output logic [bitwidth-1:0] data_out,
    output logic                isValid,
    output logic                busy,
    output logic                frameDone
);

    localparam logic [AW-1:0] c_last_addr = AW'(N - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_addr;
    logic [AW-1:0]       w_addr_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_issue;
    logic                w_gap_hold;
    logic [bitwidth-1:0] w_rd_data;

    pixel_frame_ram #(
        .WIDTH (bitwidth),
        .DEPTH (N),
        .AW    (AW)
    ) u_frame_ram (
        .clk       (clock),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // A read is issued only while streaming and not stalled; the registered
    // valid flag tracks the one-cycle RAM latency.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = STREAM;
                    w_addr_nxt  = '0;
                end
            end
            STREAM: begin
                if (!pause && !w_gap_hold) begin
                    w_issue     = 1'b1;
                    w_valid_nxt = 1'b1;
                    if (r_addr == c_last_addr) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DRAIN;
                        w_addr_nxt  = '0;
                    end else begin
                        w_addr_nxt = r_addr + AW'(1);
                    end
                end
            end
            DRAIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_addr_nxt  = '0;
            end
        endcase
    end

`ifdef PIXEL_SOURCE_GAP_EN
    logic       w_frame_start;
    logic [7:0] r_gap_cnt;
    logic [7:0] w_gap_cnt_inc;
    logic       r_gap_pending;

    assign w_frame_start = (r_state == IDLE) && start;
    assign w_gap_cnt_inc = r_gap_cnt + 8'd1;
    assign w_gap_hold    = r_gap_pending;

    // Any non-issuing STREAM cycle, pause included, pays off the owed gap.
    always_ff @(posedge clock) begin
        if (!reset_n || w_frame_start) begin
            r_gap_cnt     <= 8'd0;
            r_gap_pending <= 1'b0;
        end else if (w_issue) begin
            if ((gap_period != 8'd0) && (w_gap_cnt_inc == gap_period)) begin
                r_gap_cnt     <= 8'd0;
                r_gap_pending <= 1'b1;
            end else begin
                r_gap_cnt <= w_gap_cnt_inc;
            end
        end else if (r_state == STREAM) begin
            r_gap_pending <= 1'b0;
        end
    end
`else
    assign w_gap_hold = 1'b0;
`endif

    assign data_out  = r_valid ? w_rd_data : '0;
    assign isValid   = r_valid;
    assign busy      = (r_state != IDLE);
    assign frameDone = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_source.sv
//------------------------------------------------------------------------------
// Module   : tb_pixel_stream_source
// Brief    : Self-checking bench for pixel_stream_source (11x4 frame, 8 bit).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pixel_stream_source;

    localparam int BW = 8;
    localparam int IW = 11;
    localparam int IH = 4;
    localparam int N  = IW * IH;
    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic [7:0]    gap_period;
    logic          start;
    logic          pause;
    logic [BW-1:0] data_out;
    logic          isValid;
    logic          busy;
    logic          frameDone;

    always #5 clock = ~clock;

    pixel_stream_source #(
        .bitwidth    (BW),
        .imageWidth  (IW),
        .imageHeight (IH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`ifdef PIXEL_SOURCE_GAP_EN
        .gap_period(gap_period),
`endif
        .start     (start),
        .pause     (pause),
        .data_out  (data_out),
        .isValid   (isValid),
        .busy      (busy),
        .frameDone (frameDone)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference: frame image, index of next pixel to emit, activity phase.
    logic [BW-1:0] m_img [N];
    logic [BW-1:0] cap   [N];
    int            m_phase;
    int            m_next;
    int            m_cnt;
    bit            m_owed;
    logic          e_valid, e_busy, e_done;
    logic [BW-1:0] e_data;

    typedef struct {
        int pause_after;
        int pause_len;
        int restart_at;
        int gap;
        int exp_pixels;
        int exp_dones;
        int exp_first;
        int exp_span;
    } vec_t;

    vec_t vecs [4];
    int   n_vecs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int gp;
        @(posedge clock);
        gp = 0;
`ifdef PIXEL_SOURCE_GAP_EN
        gp = int'(gap_period);
`endif
        e_valid = 1'b0;
        e_done  = 1'b0;
        e_data  = '0;
        if (!reset_n) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_next  = 0;
                    m_cnt   = 0;
                    m_owed  = 1'b0;
                end
                1: if (!pause && !m_owed) begin
                    e_valid = 1'b1;
                    e_data  = m_img[m_next];
                    e_done  = (m_next == N - 1);
                    m_next++;
                    m_cnt++;
                    if (gp != 0 && m_cnt == gp) begin
                        m_owed = 1'b1;
                        m_cnt  = 0;
                    end
                    if (e_done) m_phase = 2;
                end else begin
                    m_owed = 1'b0;
                end
                default: m_phase = 0;
            endcase
        end
        if (wr_en && int'(wr_addr) < N) m_img[wr_addr] = wr_data;
        e_busy = (m_phase != 0);
        #1;
        check("isValid", isValid, e_valid);
        check("data_out", data_out, e_data);
        check("busy", busy, e_busy);
        check("frameDone", frameDone, e_done);
        if (e_valid) cap[m_next - 1] = data_out;
    endtask

    task automatic run_frame(input int pause_after, input int pause_len, input int restart_at,
                             output int pixels, output int dones, output int first, output int span);
        int cyc;
        int pause_left;
        int last;
        bit restarted;
        cyc = 0; pause_left = 0; last = 0; restarted = 1'b0;
        pixels = 0; dones = 0; first = -1;
        start = 1'b1;
        step();
        cyc = 1;
        start = 1'b0;
        while (m_phase != 0 && cyc < 300) begin
            pause = (pause_left > 0);
            start = (restart_at > 0 && pixels == restart_at && !restarted);
            if (start) restarted = 1'b1;
            step();
            cyc++;
            if (pause_left > 0) pause_left--;
            if (isValid) begin
                pixels++;
                if (first < 0) first = cyc;
                last = cyc;
                if (pixels == pause_after) pause_left = pause_len;
            end
            if (frameDone) dones++;
        end
        pause = 1'b0;
        start = 1'b0;
        check("frame_budget", 32'(cyc >= 300), 0);
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int px, dn, fst, spn, cyc;
        bit wrote;

        vecs[0] = '{0,  0, 0,  0, 44, 1, 2, 44};
        vecs[1] = '{19, 2, 0,  0, 44, 1, 2, 46};
        vecs[2] = '{0,  0, 10, 0, 44, 1, 2, 44};
        vecs[3] = '{0,  0, 0,  4, 44, 1, 2, 54};
        n_vecs = 3;
`ifdef PIXEL_SOURCE_GAP_EN
        n_vecs = 4;
`endif

        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; pause = 1'b0; gap_period = 8'd0;
        m_phase = 0; m_next = 0; m_cnt = 0; m_owed = 1'b0;
        step();
        step();
        check("reset_isValid", isValid, 0);
        check("reset_busy", busy, 0);
        check("reset_frameDone", frameDone, 0);
        check("reset_data_out", data_out, 0);
        reset_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = BW'(i + 1);
            step();
        end
        wr_en = 1'b0;

        for (int v = 0; v < n_vecs; v++) begin
            gap_period = 8'(vecs[v].gap);
            run_frame(vecs[v].pause_after, vecs[v].pause_len, vecs[v].restart_at, px, dn, fst, spn);
            check($sformatf("vec%0d_pixels", v), px, vecs[v].exp_pixels);
            check($sformatf("vec%0d_dones", v), dn, vecs[v].exp_dones);
            check($sformatf("vec%0d_first", v), fst, vecs[v].exp_first);
            check($sformatf("vec%0d_span", v), spn, vecs[v].exp_span);
            check($sformatf("vec%0d_last_pixel", v), cap[N-1], N);
        end
        gap_period = 8'd0;

        // Reset in the middle of a frame, then a clean restart.
        start = 1'b1; step(); start = 1'b0;
        px = 0; cyc = 0;
        while (px < 25 && cyc < 100) begin
            step(); cyc++;
            if (isValid) px++;
        end
        check("midreset_reached", px, 25);
        reset_n = 1'b0;
        step();
        check("midreset_isValid", isValid, 0);
        check("midreset_busy", busy, 0);
        reset_n = 1'b1;
        step();
        run_frame(0, 0, 0, px, dn, fst, spn);
        check("after_reset_pixels", px, N);
        check("after_reset_first_data", cap[0], 1);
        check("after_reset_last_data", cap[N-1], N);

        // Read-first collision on address 5, then an out-of-range write.
        start = 1'b1; step(); start = 1'b0;
        wrote = 1'b0; cyc = 0;
        while (m_phase != 0 && cyc < 100) begin
            if (!wrote && isValid && data_out == 8'd5) begin
                wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hAA;
                step();
                check("collision_old_data", data_out, 6);
                wr_addr = 6'd44; wr_data = 8'h77;
                wrote = 1'b1;
            end
            step(); cyc++;
            wr_en = 1'b0;
        end
        check("collision_write_seen", 32'(wrote), 1);
        run_frame(0, 0, 0, px, dn, fst, spn);
        check("collision_new_data", cap[5], 8'hAA);
        check("collision_neighbour", cap[6], 7);
        check("collision_pixels", px, N);

        // Random traffic against the reference.
        for (int c = 0; c < 600; c++) begin
            start   = ($urandom_range(0, 9) == 0);
            pause   = ($urandom_range(0, 3) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, 63));
            wr_data = BW'($urandom);
            reset_n = ($urandom_range(0, 199) != 0);
`ifdef PIXEL_SOURCE_GAP_EN
            if (m_phase == 0) gap_period = 8'($urandom_range(0, 5));
`endif
            step();
        end
        start = 1'b0; pause = 1'b0; wr_en = 1'b0; reset_n = 1'b1;
        cyc = 0;
        while (m_phase != 0 && cyc < 200) begin
            step(); cyc++;
        end
        check("random_drain_budget", 32'(cyc >= 200), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pixel_stream_source.md
PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

Interface
REQ-001 SHALL have parameter bitwidth, default 8, pixel width in bits.
REQ-002 SHALL have parameter imageWidth, default 11, pixels per row.
REQ-003 SHALL have parameter imageHeight, default 4, rows per frame; frame size N = imageWidth*imageHeight; address width AW = $clog2(N).
REQ-004 SHALL have port clock  in  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port wr_en  in  1  frame-buffer write strobe.
REQ-007 SHALL have port wr_addr  in  AW  frame-buffer write address; writes with wr_addr >= N are discarded.
REQ-008 SHALL have port wr_data  in  bitwidth  frame-buffer write data.
REQ-009 SHALL have port start  in  1  one-cycle request to stream one frame.
REQ-010 SHALL have port pause  in  1  downstream stall; holds the stream.
REQ-011 SHALL have port data_out  out  bitwidth  pixel to the convolution data_in.
REQ-012 SHALL have port isValid  out  1  data_out carries a pixel this cycle.
REQ-013 SHALL have port busy  out  1  frame in progress.
REQ-014 SHALL have port frameDone  out  1  one-cycle pulse with the last pixel of the frame.

Function
REQ-015 SHALL hold an N-entry frame buffer, written synchronously, read synchronously (one-cycle read latency).
REQ-016 SHALL implement FSM IDLE -> STREAM -> DRAIN -> IDLE.
REQ-017 IDLE: start=1 at edge k SHALL set busy=1 at k+1, read address 0; pixel 0 SHALL appear with isValid=1 at k+2.
REQ-018 STREAM: when pause=0, read address SHALL advance by 1 per cycle in raster order (row 0 col 0 .. row imageHeight-1 col imageWidth-1); pixels SHALL be emitted back-to-back with isValid=1.
REQ-019 When pause=1 at edge k, address SHALL not advance and isValid SHALL be 0 at k+1; the held pixel SHALL be emitted once pause returns to 0; no pixel lost or duplicated.
REQ-020 After address N-1 is issued, FSM SHALL enter DRAIN; the cycle pixel N-1 is emitted SHALL have isValid=1 and frameDone=1; next cycle busy=0, FSM IDLE.
REQ-021 isValid=0 cycles SHALL drive data_out to 0.
REQ-022 start while busy=1 SHALL be ignored; start on the same edge frameDone is high SHALL also be ignored.
REQ-023 Write and read of the same address on the same edge SHALL return the old data (read-first).
REQ-024 Writes during STREAM SHALL be accepted; an address already emitted shows the new value only in the next frame.

Reset
REQ-025 reset_n=0 at an edge SHALL force FSM IDLE, address 0, data_out=0, isValid=0, busy=0, frameDone=0, regardless of state (including mid-frame).
REQ-026 Frame-buffer contents SHALL not be cleared by reset.

Configuration
REQ-027 With macro PIXEL_SOURCE_GAP_EN defined, SHALL add input gap_period (8 bits) and insert one isValid=0 cycle after every gap_period emitted pixels; gap_period=0 disables gaps; gaps stack with pause (no extra delay).
REQ-028 Without PIXEL_SOURCE_GAP_EN, port gap_period SHALL not exist and the stream SHALL have no self-inserted gaps.

Structure
REQ-029 Package pixel_stream_pkg SHALL hold the FSM state enum (IDLE, STREAM, DRAIN) and default bitwidth/imageWidth/imageHeight constants shared with the convolution block.
REQ-030 Frame buffer SHALL be sub-module pixel_frame_ram (1 write port, 1 registered read port).

Verification
REQ-031 Load buffer with value = address+1 (1..44), pulse start -> isValid high 44 consecutive cycles from start+2, data 1..44, frameDone with 44, busy low next cycle.
REQ-032 Same frame, pause=1 for 2 cycles after pixel 19 -> two isValid=0 cycles, then 20..44 with no loss/duplication.
REQ-033 start pulsed at pixel 10 -> ignored; exactly 44 pixels, one frameDone.
REQ-034 reset_n=0 at pixel 25 -> next cycle isValid=0, busy=0; new start streams 1..44 from pixel 1 (buffer intact).
REQ-035 Write addr 5 = 0xAA on edge that reads addr 5 -> emits 6 this frame, 0xAA next frame; write addr 44 -> discarded.
REQ-036 With PIXEL_SOURCE_GAP_EN, gap_period=4 -> pattern 4 valid, 1 invalid; 44 pixels in 54 cycles, frameDone with 44.
